// File: rtl/control_unit.sv
// control_unit: multicycle FSM sequencing datapath control for add/sub/and/addi/lw/sw/beq/j plus exceptions
module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Zero,
  input  logic       Overflow,
  output logic       PC_write,
  output logic       A_write,
  output logic       B_write,
  output logic       EPC_write,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       IorD,
  output logic [1:0] PCSource,
  output logic       seletor_ulaA,
  output logic [1:0] seletor_ulaB,
  output logic [2:0] Seletor,
  output logic [2:0] RegDst,
  output logic [3:0] MemtoReg,
  output logic       SrctoMem,
  output logic       HI_write,
  output logic       LO_write,
  output logic       FlagRegWrite,
  output logic [2:0] ShiftOP,
  output logic       SrInputSrc,
  output logic       SrNSrc,
  output logic [1:0] load_size,
  output logic [1:0] store_size,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    RESET, FETCH0, FETCH1, DECODE, R_EXEC, ADDI_EXEC, LW_REQ, LW_WAIT,
    LW_WB, SW_WR, BEQ_CMP, BEQ_TGT, JUMP, EXC
  } state_t;
  state_t state;
  logic   take;
  logic   r_ok, is_and;
  assign is_and = funct == 6'h24;
  assign r_ok   = funct == 6'h20 || funct == 6'h22 || is_and;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET;
      take  <= 1'b0;
    end else begin
      if (state == BEQ_CMP) take <= Zero;
      case (state)
        RESET:     state <= FETCH0;
        FETCH0:    state <= FETCH1;
        FETCH1:    state <= DECODE;
        DECODE:    state <= opcode == 6'h00 ? (r_ok ? R_EXEC : EXC) :
                            opcode == 6'h08 ? ADDI_EXEC :
                            opcode == 6'h23 ? LW_REQ :
                            opcode == 6'h2B ? SW_WR :
                            opcode == 6'h04 ? BEQ_CMP :
                            opcode == 6'h02 ? JUMP : EXC;
        R_EXEC:    state <= (Overflow && !is_and) ? EXC : FETCH0;
        ADDI_EXEC: state <= Overflow ? EXC : FETCH0;
        LW_REQ:    state <= LW_WAIT;
        LW_WAIT:   state <= LW_WB;
        BEQ_CMP:   state <= BEQ_TGT;
        default:   state <= FETCH0;
      endcase
    end
  end
  assign state_dbg    = state;
  assign SrctoMem     = 1'b0;
  assign HI_write     = 1'b0;
  assign LO_write     = 1'b0;
  assign FlagRegWrite = 1'b0;
  assign ShiftOP      = 3'b000;
  assign SrInputSrc   = 1'b0;
  assign SrNSrc       = 1'b0;
  assign load_size    = 2'b00;
  assign store_size   = 2'b00;
  always_comb begin
    PC_write     = 1'b0;
    A_write      = 1'b0;
    B_write      = 1'b0;
    EPC_write    = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = 1'b0;
    IorD         = 1'b0;
    PCSource     = 2'b00;
    seletor_ulaA = 1'b0;
    seletor_ulaB = 2'b00;
    Seletor      = 3'b000;
    RegDst       = 3'b000;
    MemtoReg     = 4'b0000;
    case (state)
      FETCH1: begin
        IRWrite      = 1'b1;
        seletor_ulaB = 2'b01;
        Seletor      = 3'b001;
        PC_write     = 1'b1;
      end
      DECODE: begin
        A_write = 1'b1;
        B_write = 1'b1;
      end
      R_EXEC: begin
        seletor_ulaA = 1'b1;
        Seletor      = funct == 6'h20 ? 3'b001 : funct == 6'h22 ? 3'b010 : 3'b011;
        RegDst       = 3'b001;
        RegWrite     = !(Overflow && !is_and);
      end
      ADDI_EXEC: begin
        seletor_ulaA = 1'b1;
        seletor_ulaB = 2'b10;
        Seletor      = 3'b001;
        RegWrite     = !Overflow;
      end
      LW_REQ, LW_WAIT, LW_WB, SW_WR: begin
        IorD         = 1'b1;
        seletor_ulaA = 1'b1;
        seletor_ulaB = 2'b10;
        Seletor      = 3'b001;
        MemtoReg     = state == LW_WB ? 4'b0001 : 4'b0000;
        RegWrite     = state == LW_WB;
        MemWrite     = state == SW_WR;
      end
      BEQ_CMP: begin
        seletor_ulaA = 1'b1;
        Seletor      = 3'b010;
      end
      BEQ_TGT: begin
        seletor_ulaB = 2'b11;
        Seletor      = 3'b001;
        PC_write     = take;
      end
      JUMP: begin
        PCSource = 2'b01;
        PC_write = 1'b1;
      end
      EXC: begin
        seletor_ulaB = 2'b01;
        Seletor      = 3'b010;
        EPC_write    = 1'b1;
        PCSource     = 2'b10;
        PC_write     = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream against a per-instruction reference model, checked by a scoreboard
module tb_control_unit;
  logic clk = 0, reset = 1, Zero = 0, Overflow = 0;
  logic [5:0] opcode = 0, funct = 0;
  logic PC_write, A_write, B_write, EPC_write, IRWrite, RegWrite, MemWrite, IorD;
  logic [1:0] PCSource, seletor_ulaB, load_size, store_size;
  logic seletor_ulaA, SrctoMem, HI_write, LO_write, FlagRegWrite, SrInputSrc, SrNSrc;
  logic [2:0] Seletor, RegDst, ShiftOP;
  logic [3:0] MemtoReg, state_dbg;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero), .Overflow(Overflow),
    .PC_write(PC_write), .A_write(A_write), .B_write(B_write), .EPC_write(EPC_write),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .IorD(IorD),
    .PCSource(PCSource), .seletor_ulaA(seletor_ulaA), .seletor_ulaB(seletor_ulaB),
    .Seletor(Seletor), .RegDst(RegDst), .MemtoReg(MemtoReg), .SrctoMem(SrctoMem),
    .HI_write(HI_write), .LO_write(LO_write), .FlagRegWrite(FlagRegWrite), .ShiftOP(ShiftOP),
    .SrInputSrc(SrInputSrc), .SrNSrc(SrNSrc), .load_size(load_size), .store_size(store_size),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, aw, bw, epcw, irw, rw, mw, iord;
    logic [1:0] pcs;
    logic       ua;
    logic [1:0] ub;
    logic [2:0] sel, rd;
    logic [3:0] m2r;
    logic       consts;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // Expected control word for one cycle spent in state s
  function automatic exp_t expf(int s, logic [5:0] fn, logic ov, logic tk);
    exp_t e = '0;
    e.st = 4'(s);
    case (s)
      2:  begin e.irw = 1; e.ub = 1; e.sel = 1; e.pcw = 1; end
      3:  begin e.aw = 1; e.bw = 1; end
      4:  begin e.ua = 1; e.sel = fn == 6'h20 ? 1 : fn == 6'h22 ? 2 : 3; e.rd = 1; e.rw = !(ov && fn != 6'h24); end
      5:  begin e.ua = 1; e.ub = 2; e.sel = 1; e.rw = !ov; end
      6, 7: begin e.iord = 1; e.ua = 1; e.ub = 2; e.sel = 1; end
      8:  begin e.iord = 1; e.ua = 1; e.ub = 2; e.sel = 1; e.m2r = 1; e.rw = 1; end
      9:  begin e.iord = 1; e.ua = 1; e.ub = 2; e.sel = 1; e.mw = 1; end
      10: begin e.ua = 1; e.sel = 2; end
      11: begin e.ub = 3; e.sel = 1; e.pcw = tk; end
      12: begin e.pcs = 1; e.pcw = 1; end
      13: begin e.ub = 1; e.sel = 2; e.epcw = 1; e.pcs = 2; e.pcw = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Whole-instruction state path from FETCH0 up to (not including) the next FETCH0
  function automatic void path(input logic [5:0] op, fn, input logic ov, output int seq[$]);
    bit r_ok = fn == 6'h20 || fn == 6'h22 || fn == 6'h24;
    seq = '{1, 2, 3};
    case (op)
      6'h00: if (!r_ok) seq.push_back(13);
             else begin seq.push_back(4); if (ov && fn != 6'h24) seq.push_back(13); end
      6'h08: begin seq.push_back(5); if (ov) seq.push_back(13); end
      6'h23: seq = {seq, 6, 7, 8};
      6'h2B: seq.push_back(9);
      6'h04: seq = {seq, 10, 11};
      6'h02: seq.push_back(12);
      default: seq.push_back(13);
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{state_dbg, PC_write, A_write, B_write, EPC_write, IRWrite, RegWrite, MemWrite, IorD,
            PCSource, seletor_ulaA, seletor_ulaB, Seletor, RegDst, MemtoReg,
            |{SrctoMem, HI_write, LO_write, FlagRegWrite, ShiftOP, SrInputSrc, SrNSrc, load_size, store_size}};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL ctrl_word t=%0t state exp %0d got %0d word got %h required %h", $time, e.st, a.st, a, e);
      end
    end
  end

  task automatic step(int s, logic [5:0] fn, logic ov, logic tk);
    q.push_back(expf(s, fn, ov, tk));
    @(posedge clk); #1;
  endtask

  task automatic run(logic [5:0] op, fn, logic z, logic ov);
    int seq[$];
    opcode = op; funct = fn; Zero = z; Overflow = ov;
    path(op, fn, ov, seq);
    foreach (seq[i]) step(seq[i], fn, ov, z);
  endtask

  initial begin
    int seq[$];
    logic [5:0] op, fn;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    step(0, 0, 0, 0);
    run(6'h00, 6'h20, 0, 0);
    run(6'h23, 6'h00, 0, 0);
    run(6'h04, 6'h00, 1, 0);
    run(6'h04, 6'h00, 0, 0);
    run(6'h08, 6'h00, 0, 1);
    run(6'h3F, 6'h00, 0, 0);
    run(6'h00, 6'h2A, 0, 0);
    run(6'h02, 6'h00, 0, 0);
    run(6'h00, 6'h24, 0, 1);
    run(6'h00, 6'h22, 1, 1);
    // store interrupted by a 3-edge reset: SW_WR still visible, then RESET, then FETCH0
    opcode = 6'h2B; funct = 0; Zero = 0; Overflow = 0;
    step(1, 0, 0, 0); step(2, 0, 0, 0); step(3, 0, 0, 0);
    reset = 1;
    step(9, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    reset = 0;
    step(0, 0, 0, 0);
    run(6'h2B, 6'h00, 0, 0);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0: begin op = 6'h00; fn = 6'h20; end
        1: begin op = 6'h00; fn = 6'h22; end
        2: begin op = 6'h00; fn = 6'h24; end
        3: begin op = 6'h08; fn = 6'($urandom); end
        4: begin op = 6'h23; fn = 6'($urandom); end
        5: begin op = 6'h2B; fn = 6'($urandom); end
        6: begin op = 6'h04; fn = 6'($urandom); end
        7: begin op = 6'h02; fn = 6'($urandom); end
        8: begin op = 6'($urandom); fn = 6'($urandom); end
        default: begin op = 6'h00; fn = 6'($urandom); end
      endcase
      run(op, fn, 1'($urandom), 1'($urandom));
    end
    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control FSM that drives every control input of the `cpu` datapath (register write enables, mux selects, ALU `Seletor`, memory write) from the fetched opcode/funct and the ALU flags. It is the issuing end of the datapath control interface: the datapath consumes these signals, and this block sequences them per instruction. The supported subset is add, sub, and, addi, lw, sw, beq and j, plus an overflow/illegal-instruction exception path.

## Interface
- No parameters. Opcode, funct and state encodings are fixed below.
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  6  IR[31:26]
- `funct`  in  6  IR[5:0]
- `Zero`, `Overflow`  in  1 each  ALU flags, combinational from the current ALU operation
- `PC_write`, `A_write`, `B_write`, `EPC_write`, `IRWrite`, `RegWrite`, `MemWrite`  out  1 each  write enables
- `IorD`  out  1  memory address: 0 = PC, 1 = ULA_out
- `PCSource`  out  2  PC input: 00 = ULA_out, 01 = jump target {PC[31:28], IR[25:0], 2'b00}, 10 = vector 32'h0000_00FC
- `seletor_ulaA`  out  1  0 = PC, 1 = A
- `seletor_ulaB`  out  2  00 = B, 01 = const 4, 10 = sign-extend, 11 = sign-extend<<2
- `Seletor`  out  3  ALU op: 001 = add, 010 = sub, 011 = and
- `RegDst`  out  3  000 = rt, 001 = rd
- `MemtoReg`  out  4  0000 = ULA_out, 0001 = MemData
- `SrctoMem`  out  1  fixed 0 (B_out)
- `HI_write`, `LO_write`, `FlagRegWrite`, `ShiftOP`, `SrInputSrc`, `SrNSrc`, `load_size`, `store_size`  out  datapath widths  constant 0 in this revision
- `state_dbg`  out  4  current state encoding

## Operation
- States and encodings: RESET 0, FETCH0 1, FETCH1 2, DECODE 3, R_EXEC 4, ADDI_EXEC 5, LW_REQ 6, LW_WAIT 7, LW_WB 8, SW_WR 9, BEQ_CMP 10, BEQ_TGT 11, JUMP 12, EXC 13.
- Outputs are a function of state only, except where noted. Any output not listed for a state is 0.
- RESET: all outputs 0. Next state is FETCH0.
- FETCH0: IorD=0, which presents PC to memory. Next state is FETCH1.
- FETCH1: IorD=0, IRWrite=1, ALU computes PC+4 (ulaA=0, ulaB=01, Seletor=001), PCSource=00, PC_write=1. Next state is DECODE.
- DECODE: A_write=1, B_write=1. Dispatch by opcode:
  - 0x00 → R_EXEC if funct ∈ {0x20, 0x22, 0x24}, otherwise EXC
  - 0x08 → ADDI_EXEC; 0x23 → LW_REQ; 0x2B → SW_WR; 0x04 → BEQ_CMP; 0x02 → JUMP
  - any other opcode → EXC
- R_EXEC: ulaA=1, ulaB=00, Seletor = 001/010/011 for funct 0x20/0x22/0x24, RegDst=001, MemtoReg=0000.
  - RegWrite = !(Overflow && funct≠0x24). This is a combinational dependence on the input.
  - Next state: EXC on add/sub overflow, otherwise FETCH0.
- ADDI_EXEC: ulaA=1, ulaB=10, Seletor=001, RegDst=000, RegWrite=!Overflow. Next state: EXC on overflow, otherwise FETCH0.
- LW_REQ, LW_WAIT, LW_WB: all three hold IorD=1, ulaA=1, ulaB=10, Seletor=001.
  - LW_WB additionally drives MemtoReg=0001, RegDst=000, RegWrite=1.
  - Sequence is LW_REQ → LW_WAIT → LW_WB → FETCH0.
- SW_WR: IorD=1, ulaA=1, ulaB=10, Seletor=001, MemWrite=1. Next state is FETCH0.
- BEQ_CMP: ulaA=1, ulaB=00, Seletor=010. The internal bit `take` is registered from Zero. Next state is BEQ_TGT.
- BEQ_TGT: ulaA=0, ulaB=11, Seletor=001, PCSource=00, PC_write=`take`. Next state is FETCH0.
- JUMP: PCSource=01, PC_write=1. Next state is FETCH0.
- EXC: ALU computes PC−4 (ulaA=0, ulaB=01, Seletor=010), EPC_write=1, PCSource=10, PC_write=1. Next state is FETCH0.

## Timing
- Reset: while `reset`=1 at a rising edge, the next state is RESET and `take` is set to 0.
  - Reset overrides any state, including mid-instruction. A store in progress is aborted because MemWrite is 0 in RESET.
  - Reset-mid-operation is safe because no write enable is asserted in RESET.
  - After `reset` is released, FETCH0 is reached one cycle later.
- Memory read latency is 1 cycle. The address is held for ≥2 cycles before IRWrite or MemtoReg capture.
- Cycles per instruction, counted from FETCH0:
  - R-type, addi, sw, j: 4
  - beq: 5
  - lw: 6
  - exception: +1 (EXC)
- Write enables are asserted for exactly one cycle per visit to the state.
- PC update from FETCH1 is visible to the ALU from DECODE onward. BEQ_TGT therefore adds the offset to PC+4.
- Overflow during an and (funct 0x24) is ignored.

## Test plan
- Reset held 3 cycles in the middle of SW_WR → MemWrite drops the same cycle reset is sampled, state_dbg=0, then 1 on the next cycle, and all enables are 0 during reset.
- add (op 0x00, funct 0x20), Overflow=0 → state_dbg sequence 1,2,3,4,1. IRWrite+PC_write only in FETCH1, RegWrite=1 with RegDst=001, Seletor=001 in R_EXEC.
- lw (0x23) → sequence 1,2,3,6,7,8,1. IorD=1 for states 6–8, RegWrite=1 only in state 8 with MemtoReg=0001.
- beq (0x04) with Zero=1 in BEQ_CMP → PC_write=1 in BEQ_TGT with ulaB=11. Repeated with Zero=0 → PC_write=0.
- addi (0x08) with Overflow=1 → RegWrite=0, next state 13 with EPC_write=1, PCSource=10, Seletor=010, then back to FETCH0.
- Illegal opcode 0x3F and R-type funct 0x2A → DECODE goes directly to EXC (state 13). j (0x02) → PCSource=01, PC_write=1 in state 12.
